// File: rtl/csr_file.sv
// rtl/csr_file.sv - machine-mode CSR register file with dual write ports, read bypass and mcycle
//
// Ports:
//   clk, rst                      core clock, synchronous active-high reset
//   ex_we_i/ex_waddr_i/ex_wdata_i     EX-stage CSR write port
//   int_we_i/int_waddr_i/int_wdata_i  interrupt-controller CSR write port (wins on address clash)
//   raddr_i/rdata_o               combinational read port with same-cycle write bypass
//   global_int_en_o               mstatus.MIE
//   csr_mtvec_o/csr_mepc_o/csr_mstatus_o  registered CSR exports (no bypass)
module csr_file #(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
    parameter logic [31:0] MHARTID     = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_we_i,
    input  logic [31:0] ex_waddr_i,
    input  logic [31:0] ex_wdata_i,
    input  logic        int_we_i,
    input  logic [31:0] int_waddr_i,
    input  logic [31:0] int_wdata_i,
    input  logic [31:0] raddr_i,
    output logic [31:0] rdata_o,
    output logic        global_int_en_o,
    output logic [31:0] csr_mtvec_o,
    output logic [31:0] csr_mepc_o,
    output logic [31:0] csr_mstatus_o
);

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MISA     = 12'h301;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MCYCLEH  = 12'hB80;
    localparam logic [11:0] A_MHARTID  = 12'hF14;

    localparam logic [31:0] MSTATUS_RST = 32'h0000_1800;
    localparam logic [31:0] MISA_VAL    = 32'h4000_0100;

    logic [31:0] mstatus_q, mstatus_d;
    logic [31:0] mie_q, mie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [63:0] mcycle_q, mcycle_d;

    function automatic logic is_writable(input logic [11:0] a);
        case (a)
            A_MSTATUS, A_MIE, A_MTVEC, A_MSCRATCH,
            A_MEPC, A_MCAUSE, A_MCYCLE, A_MCYCLEH: is_writable = 1'b1;
            default:                               is_writable = 1'b0;
        endcase
    endfunction

    // Value the register will actually hold after a write of d to a.
    function automatic logic [31:0] mask_wr(input logic [11:0] a, input logic [31:0] d);
        case (a)
            A_MSTATUS:      mask_wr = (d & 32'h0000_0088) | MSTATUS_RST;
            A_MTVEC, A_MEPC: mask_wr = d & 32'hFFFF_FFFC;
            default:        mask_wr = d;
        endcase
    endfunction

    logic [11:0] ex_a, int_a, rd_a;
    logic        ex_ok, int_ok;
    logic [31:0] ex_m, int_m;
    logic [63:0] cnt_inc;
    logic [31:0] reg_rdata;

    assign ex_a  = ex_waddr_i[11:0];
    assign int_a = int_waddr_i[11:0];
    assign rd_a  = raddr_i[11:0];
    assign ex_m  = mask_wr(ex_a, ex_wdata_i);
    assign int_m = mask_wr(int_a, int_wdata_i);

    // Read-only and unimplemented targets never count as writes, so they cannot
    // bypass onto the read port or block the other port.
    assign int_ok = int_we_i && is_writable(int_a);
    assign ex_ok  = ex_we_i && is_writable(ex_a) && !(int_ok && (int_a == ex_a));

    assign cnt_inc = mcycle_q + 64'd1;

    always_comb begin
        mstatus_d  = mstatus_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        // A written half replaces its incremented value; the other half keeps
        // the carry-propagated increment from the previous count.
        mcycle_d   = cnt_inc;
        if (ex_ok) begin
            case (ex_a)
                A_MSTATUS:  mstatus_d  = ex_m;
                A_MIE:      mie_d      = ex_m;
                A_MTVEC:    mtvec_d    = ex_m;
                A_MSCRATCH: mscratch_d = ex_m;
                A_MEPC:     mepc_d     = ex_m;
                A_MCAUSE:   mcause_d   = ex_m;
                A_MCYCLE:   mcycle_d[31:0]  = ex_m;
                A_MCYCLEH:  mcycle_d[63:32] = ex_m;
                default: ;
            endcase
        end
        if (int_ok) begin
            case (int_a)
                A_MSTATUS:  mstatus_d  = int_m;
                A_MIE:      mie_d      = int_m;
                A_MTVEC:    mtvec_d    = int_m;
                A_MSCRATCH: mscratch_d = int_m;
                A_MEPC:     mepc_d     = int_m;
                A_MCAUSE:   mcause_d   = int_m;
                A_MCYCLE:   mcycle_d[31:0]  = int_m;
                A_MCYCLEH:  mcycle_d[63:32] = int_m;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_q  <= MSTATUS_RST;
            mie_q      <= 32'h0;
            mtvec_q    <= RESET_MTVEC & 32'hFFFF_FFFC;
            mscratch_q <= 32'h0;
            mepc_q     <= 32'h0;
            mcause_q   <= 32'h0;
            mcycle_q   <= 64'h0;
        end else begin
            mstatus_q  <= mstatus_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mcycle_q   <= mcycle_d;
        end
    end

    always_comb begin
        reg_rdata = 32'h0;
        case (rd_a)
            A_MSTATUS:  reg_rdata = mstatus_q;
            A_MISA:     reg_rdata = MISA_VAL;
            A_MIE:      reg_rdata = mie_q;
            A_MTVEC:    reg_rdata = mtvec_q;
            A_MSCRATCH: reg_rdata = mscratch_q;
            A_MEPC:     reg_rdata = mepc_q;
            A_MCAUSE:   reg_rdata = mcause_q;
            A_MCYCLE:   reg_rdata = mcycle_q[31:0];
            A_MCYCLEH:  reg_rdata = mcycle_q[63:32];
            A_MHARTID:  reg_rdata = MHARTID;
            default:    reg_rdata = 32'h0;
        endcase
    end

    always_comb begin
        rdata_o = reg_rdata;
        if (int_ok && (int_a == rd_a)) begin
            rdata_o = int_m;
        end else if (ex_ok && (ex_a == rd_a)) begin
            rdata_o = ex_m;
        end
    end

    assign global_int_en_o = mstatus_q[3];
    assign csr_mtvec_o     = mtvec_q;
    assign csr_mepc_o      = mepc_q;
    assign csr_mstatus_o   = mstatus_q;

endmodule

// File: tb/tb_csr_file.sv
// tb/tb_csr_file.sv - directed self-checking bench for csr_file
module tb_csr_file;

    logic        clk;
    logic        rst;
    logic        ex_we_i;
    logic [31:0] ex_waddr_i;
    logic [31:0] ex_wdata_i;
    logic        int_we_i;
    logic [31:0] int_waddr_i;
    logic [31:0] int_wdata_i;
    logic [31:0] raddr_i;
    logic [31:0] rdata_o;
    logic        global_int_en_o;
    logic [31:0] csr_mtvec_o;
    logic [31:0] csr_mepc_o;
    logic [31:0] csr_mstatus_o;

    int n_cmp;
    int n_bad;

    csr_file #(
        .RESET_MTVEC(32'h0000_0000),
        .MHARTID    (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_we_i        (ex_we_i),
        .ex_waddr_i     (ex_waddr_i),
        .ex_wdata_i     (ex_wdata_i),
        .int_we_i       (int_we_i),
        .int_waddr_i    (int_waddr_i),
        .int_wdata_i    (int_wdata_i),
        .raddr_i        (raddr_i),
        .rdata_o        (rdata_o),
        .global_int_en_o(global_int_en_o),
        .csr_mtvec_o    (csr_mtvec_o),
        .csr_mepc_o     (csr_mepc_o),
        .csr_mstatus_o  (csr_mstatus_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs and checks happen mid-low-phase.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        raddr_i = a;
        #1;
        check_eq(tag, rdata_o, exp);
    endtask

    task automatic ex_wr(input logic [31:0] a, input logic [31:0] d);
        ex_we_i = 1'b1; ex_waddr_i = a; ex_wdata_i = d;
    endtask

    task automatic int_wr(input logic [31:0] a, input logic [31:0] d);
        int_we_i = 1'b1; int_waddr_i = a; int_wdata_i = d;
    endtask

    task automatic idle();
        ex_we_i = 1'b0; int_we_i = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        ex_we_i = 1'b0; ex_waddr_i = 32'h0; ex_wdata_i = 32'h0;
        int_we_i = 1'b0; int_waddr_i = 32'h0; int_wdata_i = 32'h0;
        raddr_i = 32'h0;
        step();
        step();
        rst = 1'b0;

        // Reset state and five idle cycles
        repeat (5) step();
        check_eq("rst_gie", {31'h0, global_int_en_o}, 32'h0);
        check_eq("rst_mtvec", csr_mtvec_o, 32'h0);
        check_eq("rst_mepc", csr_mepc_o, 32'h0);
        check_eq("rst_mstatus_o", csr_mstatus_o, 32'h0000_1800);
        rd("rst_mstatus_rd", 32'h300, 32'h0000_1800);
        rd("mcycle_5", 32'hB00, 32'd5);
        rd("mhartid", 32'hF14, 32'h0);
        rd("unimpl_7c0", 32'h7C0, 32'h0);
        rd("misa", 32'h301, 32'h4000_0100);

        // EX mstatus write with bypass
        ex_wr(32'h300, 32'hFFFF_FFFF);
        rd("mstatus_bypass", 32'h300, 32'h0000_1888);
        check_eq("mstatus_o_nobypass", csr_mstatus_o, 32'h0000_1800);
        step();
        idle();
        check_eq("mstatus_o_after", csr_mstatus_o, 32'h0000_1888);
        check_eq("gie_set", {31'h0, global_int_en_o}, 32'h1);

        // Same-address clash: int wins
        int_wr(32'h341, 32'h0000_0104);
        ex_wr(32'h341, 32'h0000_0200);
        rd("mepc_clash_bypass", 32'h341, 32'h0000_0104);
        step();
        idle();
        check_eq("mepc_clash", csr_mepc_o, 32'h0000_0104);
        ex_wr(32'h341, 32'h0000_0107);
        step();
        idle();
        rd("mepc_align", 32'h341, 32'h0000_0104);

        // Different addresses both commit; read-only write ignored
        int_wr(32'h340, 32'hA5A5_0001);
        ex_wr(32'h304, 32'h0000_0888);
        rd("mie_bypass_ex", 32'h304, 32'h0000_0888);
        step();
        idle();
        rd("mscratch_both", 32'h340, 32'hA5A5_0001);
        rd("mie_both", 32'h304, 32'h0000_0888);
        ex_wr(32'h301, 32'h0);
        rd("misa_ro_bypass", 32'h301, 32'h4000_0100);
        step();
        idle();
        rd("misa_ro", 32'h301, 32'h4000_0100);

        // Interrupt-controller sequence
        int_wr(32'h341, 32'h0000_0080);
        step();
        check_eq("seq_mepc", csr_mepc_o, 32'h0000_0080);
        int_wr(32'h342, 32'h8000_000B);
        step();
        rd("seq_mcause", 32'h342, 32'h8000_000B);
        check_eq("seq_gie_before", {31'h0, global_int_en_o}, 32'h1);
        int_wr(32'h300, 32'h0000_1880);
        step();
        idle();
        check_eq("seq_mstatus", csr_mstatus_o, 32'h0000_1880);
        check_eq("seq_gie_clr", {31'h0, global_int_en_o}, 32'h0);

        // mcycle load and wrap
        ex_wr(32'hB00, 32'hFFFF_FFFE);
        rd("mcycle_bypass", 32'hB00, 32'hFFFF_FFFE);
        step();
        ex_wr(32'hB80, 32'hFFFF_FFFF);
        rd("mcycle_lo_loaded", 32'hB00, 32'hFFFF_FFFE);
        step();
        idle();
        rd("mcycle_lo_ff", 32'hB00, 32'hFFFF_FFFF);
        rd("mcycleh_ff", 32'hB80, 32'hFFFF_FFFF);
        step();
        rd("mcycle_wrap", 32'hB00, 32'h0);
        rd("mcycleh_wrap", 32'hB80, 32'h0);

        // Reset beats a simultaneous write
        ex_wr(32'h305, 32'h0000_2003);
        step();
        idle();
        check_eq("mtvec_written", csr_mtvec_o, 32'h0000_2000);
        int_wr(32'h305, 32'h0000_1000);
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle();
        check_eq("rst2_mtvec", csr_mtvec_o, 32'h0);
        check_eq("rst2_mepc", csr_mepc_o, 32'h0);
        check_eq("rst2_mstatus", csr_mstatus_o, 32'h0000_1800);
        check_eq("rst2_gie", {31'h0, global_int_en_o}, 32'h0);
        rd("rst2_mcycle", 32'hB00, 32'h0);
        rd("rst2_mie", 32'h304, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/csr_file.md
# csr_file

Machine-mode CSR register file for the yadan core, and the write-side responder for the interrupt controller's CSR update sequence. Accepts two write ports: the EX-stage CSR-instruction port and the interrupt-controller port. Provides a combinational read port to ID/EX with same-cycle write bypass. Exports mtvec, mepc, mstatus and the global interrupt enable back to the interrupt controller, and runs the 64-bit mcycle counter.

## Interface
- RESET_MTVEC, 32'h0000_0000, reset value of mtvec (bits [1:0] forced 0)
- MHARTID, 32'h0000_0000, constant returned for mhartid
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high; sampled on rising clk
- ex_we_i  in  1  EX CSR write enable
- ex_waddr_i  in  32  EX CSR address (only [11:0] decoded)
- ex_wdata_i  in  32  EX CSR write data
- int_we_i  in  1  interrupt-controller write enable
- int_waddr_i  in  32  interrupt-controller CSR address (only [11:0] decoded)
- int_wdata_i  in  32  interrupt-controller write data
- raddr_i  in  32  read address (only [11:0] decoded)
- rdata_o  out  32  read data, combinational
- global_int_en_o  out  1  mstatus.MIE
- csr_mtvec_o  out  32  mtvec register
- csr_mepc_o  out  32  mepc register
- csr_mstatus_o  out  32  mstatus register

## Operation
- Implemented CSRs (addr: reset / write rule):
  - mstatus 0x300: 32'h0000_1800. Writable bits: MIE[3], MPIE[7]. MPP[12:11] reads 2'b11. All other bits read 0.
  - misa 0x301: read-only constant 32'h4000_0100 (RV32I). Writes ignored.
  - mie 0x304: 0. Full 32-bit write.
  - mtvec 0x305: RESET_MTVEC. Bits [1:0] forced 0.
  - mscratch 0x340: 0. Full write.
  - mepc 0x341: 0. Bits [1:0] forced 0.
  - mcause 0x342: 0. Full write.
  - mcycle 0xB00 / mcycleh 0xB80: 0. Low/high halves of the 64-bit counter.
  - mhartid 0xF14: MHARTID. Read-only.
- Unimplemented address: reads return 0; writes are ignored. No exception is raised.
- Both write ports may fire in the same cycle:
  - Different addresses: both writes commit.
  - Same address: int port wins and the EX write is dropped.
- Writes to read-only CSRs are ignored on either port.
- mcycle: increments by 1 every cycle out of reset. Wraps from 64'hFFFF_FFFF_FFFF_FFFF to 0.
  - Write to mcycle: low half loads the write data; high half takes its incremented-carry value from the previous count.
  - Write to mcycleh: high half loads; low half increments normally.
  - A written half does not increment in the write cycle.
- Read bypass, same cycle, applied to the masked value:
  - raddr_i matches an active int write: rdata_o shows that data.
  - Else raddr_i matches an active EX write: rdata_o shows that data.
  - Else rdata_o shows the register value.
  - mcycle/mcycleh reads without a matching write return the current (pre-increment) register value.
- Exported outputs come straight from the registers, with no bypass. global_int_en_o = mstatus[3].

## Timing
- Writes take effect on the rising clk edge where the write enable is high. Exported outputs change one cycle after the write.
- rdata_o has zero latency, combinational from raddr_i and the write ports.
- The interrupt controller issues one write per cycle in this order: mepc, then mcause, then mstatus (MIE cleared). Each write must be visible on csr_* outputs in the cycle after it commits, so the next step reads updated values.
- Reset takes priority over all writes and the counter. Asserting rst mid-sequence returns every register to its reset value at that edge.
- Reset output values: global_int_en_o=0, csr_mtvec_o=RESET_MTVEC&~3, csr_mepc_o=0, csr_mstatus_o=32'h0000_1800.

## Test plan
- Reset then idle 5 cycles: mstatus reads 32'h0000_1800, mcycle reads 5, mhartid reads MHARTID, and an unimplemented address (0x7C0) reads 0.
- EX writes mstatus=32'hFFFF_FFFF: next cycle csr_mstatus_o=32'h0000_1888 and global_int_en_o=1. In the write cycle, a read of 0x300 returns 32'h0000_1888.
- Same cycle, int port writes mepc=32'h0000_0104 and EX writes mepc=32'h0000_0200: csr_mepc_o=32'h0000_0104. Also write mepc=32'h0000_0107 and check it reads 32'h0000_0104.
- Int sequence mepc=0x80, then mcause=32'h8000_000B, then mstatus=32'h0000_1880 on consecutive cycles: each value visible on outputs/reads in the next cycle, and global_int_en_o falls to 0 after the third write.
- EX writes mcycle=32'hFFFF_FFFE and mcycleh=32'hFFFF_FFFF: two cycles later mcycle=0 and mcycleh=0, showing wrap.
- Assert rst in the same cycle as int_we_i writing mtvec=32'h0000_1000: csr_mtvec_o=RESET_MTVEC and all other outputs hold their reset values.
